intr_arbiter: RTL and testbench
===============================

// Module: intr_arbiter
// PURPOSE
//  Shares the Unibus interrupt path among NDEV emulated devices (KL11, DL11, RL11, ...).
//  Collects per-device intreq/irvec/level and drives one BR line toward the PDP.
//  On the matching BG, broadcasts intgnt+igvec to all devices for one cycle.
//  Sits between device intreq/irvec outputs and the bus BR/BG interface; ARM-visible config/status.
// PARAMETERS
//  NDEV   8   number of requesting devices, 1..16; index 0 = highest priority within a level
//  TMOUT  255 cycles to wait for the granted device to drop intreq before flagging an error
// PORTS
//  CLOCK        in   1        system clock
//  RESET        in   1        synchronous, active-high; clears all state and config
//  armwrite     in   1        ARM register write strobe
//  armraddr     in   2        ARM read register select
//  armwaddr     in   2        ARM write register select
//  armwdata     in   32       ARM write data
//  armrdata     out  32       ARM read data (combinational from armraddr)
//  init_in_h    in   1        Unibus INIT; aborts arbitration, keeps config
//  dev_intreq   in   NDEV     per-device interrupt request
//  dev_irvec    in   NDEV*8   per-device vector, device i at [8i+7:8i]
//  dev_level    in   NDEV*2   per-device BR level, 0..3 = BR4..BR7
//  bus_br       out  4        BR7..BR4 request to PDP, bit k = BR(4+k), at most one set
//  bus_bg       in   4        bus grant from PDP, bit k = BG(4+k)
//  intgnt       out  1        grant pulse to all devices
//  igvec        out  8        vector of granted device, valid while intgnt
// BEHAVIOUR
//  Registers: reg0 RO ID 32'h49410100 ('IA', 4 regs, v0x100); reg1 ctl/status; reg2 stats; reg3 RO 0.
//  reg1 read: [31]enable [30]tmoflag [29:28]state [27:24]last sel [23:16]last vector [15:0]mask
//   (mask bits >= NDEV read 0). Write: enable<=d[31]; d[30]=1 clears tmoflag; mask<=d[15:0].
//  RESET: enable=0, mask=0, tmoflag=0, state=IDLE, bus_br=0, intgnt=0, igvec=0, sel=0, lastvec=0.
//  init_in_h (RESET low): state=IDLE, bus_br=0, intgnt=0, igvec=0; enable/mask/tmoflag/stats kept.
//  Eligible(i) = enable & mask[i] & dev_intreq[i].
//  IDLE: if any eligible, choose highest dev_level, ties -> lowest index; latch sel, level,
//   vector; next cycle state=REQ and bus_br[level]=1 (1-cycle latency). Else remain IDLE.
//  REQ: holds bus_br; selection is NOT re-evaluated (no preemption).
//   dev_intreq[sel]=0 or ~enable or ~mask[sel] -> bus_br=0, IDLE (request withdrawn).
//   bus_bg[level]=1 -> bus_br=0, intgnt=1, igvec=latched vector for exactly one cycle, state=GRANT.
//   bus_bg on any other bit is ignored. Withdraw and grant in same cycle: grant wins.
//  GRANT: intgnt=0, igvec=0; counter loads 0; state=DROP.
//  DROP: wait for dev_intreq[sel]=0 -> IDLE. If counter reaches TMOUT -> tmoflag=1, IDLE.
//   A new request from the same device is only honoured after it has dropped (or timed out).
//  Level/vector inputs sampled only in IDLE; later changes do not affect the pending request.
//  Timeout counter 8 bits, saturates; not affected by ARM writes.
//  ARM write and state update in the same cycle: write takes effect, FSM evaluates old config.
// CONFIGURATION
//  INTARB_STATS_EN defined: reg2 = 32-bit count of intgnt pulses, wraps at 2^32;
//   any write to reg2 clears it (write wins over simultaneous increment); cleared by RESET only.
//  INTARB_STATS_EN undefined: reg2 reads 0, writes ignored, no counter logic.
// TESTING
//  Reset, read reg0 -> 32'h49410100; reg1 -> 0; bus_br=0, intgnt=0.
//  enable, mask=0x01, dev0 intreq level 2 vec 8'o100 -> bus_br=4'b0100 next cycle; bg[2] ->
//   intgnt=1, igvec=8'o100 one cycle; dev drops -> IDLE, reg1[23:16]=8'o100.
//  dev1 level 1 + dev3 level 3 + dev2 level 3 same cycle -> dev2 selected, bus_br=4'b1000.
//  REQ for dev0, dev0 drops before bg -> bus_br=0 next cycle, IDLE, no intgnt; bg[0] while
//   requesting level 2 -> ignored.
//  Granted device holds intreq 256 cycles -> tmoflag=1, IDLE; write reg1 d[30]=1 clears flag.
//  init_in_h during REQ -> bus_br=0, IDLE, mask/enable unchanged; with INTARB_STATS_EN,
//   3 grants -> reg2=3, write reg2 -> 0.

Source files
------------

// File: rtl/intr_arbiter.sv
// Unibus interrupt arbiter: picks one of NDEV device requests, drives a single BR line, broadcasts the grant.
// Optional macro INTARB_STATS_EN adds a 32-bit grant counter readable/clearable at ARM register 2.
module intr_arbiter #(
   parameter int NDEV  = 8,
   parameter int TMOUT = 255
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                armwrite,
   input  logic [1:0]          armraddr,
   input  logic [1:0]          armwaddr,
   input  logic [31:0]         armwdata,
   output logic [31:0]         armrdata,
   input  logic                init_in_h,
   input  logic [NDEV-1:0]     dev_intreq,
   input  logic [NDEV*8-1:0]   dev_irvec,
   input  logic [NDEV*2-1:0]   dev_level,
   output logic [3:0]          bus_br,
   input  logic [3:0]          bus_bg,
   output logic                intgnt,
   output logic [7:0]          igvec
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_GRANT = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   localparam logic [31:0] ID_VALUE = 32'h4941_0100;
   localparam logic [15:0] DEV_MASK = 16'((32'd1 << NDEV) - 32'd1);
   localparam logic [7:0]  TMO_LIM  = 8'(TMOUT);

   state_t      state;
   logic        enable;
   logic        tmoflag;
   logic [15:0] mask;
   logic [3:0]  sel;
   logic [1:0]  lvl;
   logic [7:0]  vec;
   logic [7:0]  cnt;
   logic [31:0] stats;

   // Device inputs padded to 16 devices so a 4-bit select indexes them without width games.
   logic [15:0]  req_pad;
   logic [127:0] vec_pad;
   logic [31:0]  lvl_pad;
   logic [15:0]  eligible;

   assign req_pad  = 16'(dev_intreq);
   assign vec_pad  = 128'(dev_irvec);
   assign lvl_pad  = 32'(dev_level);
   assign eligible = {16{enable}} & mask & req_pad;

   logic       any_elig;
   logic [3:0] best_idx;
   logic [1:0] best_lvl;

   // Scanning downward with >= lets the lower index win a tie at the same level.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      any_elig = 1'b0;
      best_idx = 4'd0;
      best_lvl = 2'd0;
      for (int i = 15; i >= 0; i--) begin
         if (eligible[i] && (!any_elig || lvl_pad[2*i +: 2] >= best_lvl)) begin
            any_elig = 1'b1;
            best_idx = 4'(i);
            best_lvl = lvl_pad[2*i +: 2];
         end
      end
   end

   logic wr_reg1;
   logic withdraw;

   assign wr_reg1  = armwrite && (armwaddr == 2'd1);
   assign withdraw = !req_pad[sel] || !enable || !mask[sel];

   // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         enable  <= 1'b0;
         tmoflag <= 1'b0;
         mask    <= 16'd0;
         sel     <= 4'd0;
         lvl     <= 2'd0;
         vec     <= 8'd0;
         cnt     <= 8'd0;
         bus_br  <= 4'd0;
         intgnt  <= 1'b0;
         igvec   <= 8'd0;
      end else begin
         if (init_in_h) begin
            state  <= ST_IDLE;
            bus_br <= 4'd0;
            intgnt <= 1'b0;
            igvec  <= 8'd0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (any_elig) begin
                     sel    <= best_idx;
                     lvl    <= best_lvl;
                     vec    <= vec_pad[8*best_idx +: 8];
                     bus_br <= 4'b0001 << best_lvl;
                     state  <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  // Grant has priority over a same-cycle withdrawal.
                  if (bus_bg[lvl]) begin
                     bus_br <= 4'd0;
                     intgnt <= 1'b1;
                     igvec  <= vec;
                     state  <= ST_GRANT;
                  end else if (withdraw) begin
                     bus_br <= 4'd0;
                     state  <= ST_IDLE;
                  end
               end
               ST_GRANT: begin
                  intgnt <= 1'b0;
                  igvec  <= 8'd0;
                  cnt    <= 8'd0;
                  state  <= ST_DROP;
               end
               ST_DROP: begin
                  if (!req_pad[sel]) begin
                     state <= ST_IDLE;
                  end else if (cnt == TMO_LIM) begin
                     tmoflag <= 1'b1;
                     state   <= ST_IDLE;
                  end else if (cnt != 8'hFF) begin
                     cnt <= cnt + 8'd1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         // Placed after the FSM so an ARM clear of tmoflag overrides a same-cycle timeout.
         if (wr_reg1) begin
            enable <= armwdata[31];
            mask   <= armwdata[15:0] & DEV_MASK;
            if (armwdata[30]) tmoflag <= 1'b0;
         end
      end
   end

`ifdef INTARB_STATS_EN
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         stats <= 32'd0;
      end else if (armwrite && (armwaddr == 2'd2)) begin
         stats <= 32'd0;
      end else if (intgnt) begin
         stats <= stats + 32'd1;
      end
   end
`else
   assign stats = 32'd0;
`endif

   logic unused_wdata;
   assign unused_wdata = ^armwdata[29:16];

   always_comb begin
      armrdata = 32'd0;
      case (armraddr)
         2'd0: armrdata = ID_VALUE;
         2'd1: armrdata = {enable, tmoflag, state, sel, vec, mask};
         2'd2: armrdata = stats;
         default: armrdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed self-checking bench for intr_arbiter with hand-computed expectations (NDEV=8, TMOUT=255).
module tb_intr_arbiter;

   localparam int NDEV = 8;

   logic              CLOCK = 1'b0;
   logic              RESET;
   logic              armwrite;
   logic [1:0]        armraddr;
   logic [1:0]        armwaddr;
   logic [31:0]       armwdata;
   logic [31:0]       armrdata;
   logic              init_in_h;
   logic [NDEV-1:0]   dev_intreq;
   logic [NDEV*8-1:0] dev_irvec;
   logic [NDEV*2-1:0] dev_level;
   logic [3:0]        bus_br;
   logic [3:0]        bus_bg;
   logic              intgnt;
   logic [7:0]        igvec;

   int checks = 0;
   int errors = 0;

   intr_arbiter #(.NDEV(NDEV), .TMOUT(255)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .init_in_h(init_in_h),
      .dev_intreq(dev_intreq), .dev_irvec(dev_irvec), .dev_level(dev_level),
      .bus_br(bus_br), .bus_bg(bus_bg), .intgnt(intgnt), .igvec(igvec)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
      armwrite = 1'b1;
      armwaddr = a;
      armwdata = d;
      tick();
      armwrite = 1'b0;
   endtask

   task automatic arm_read(input logic [1:0] a, output logic [31:0] d);
      armraddr = a;
      #1;
      d = armrdata;
   endtask

   task automatic set_dev(input int i, input logic req, input logic [1:0] lv, input logic [7:0] v);
      dev_intreq[i]       = req;
      dev_level[2*i +: 2] = lv;
      dev_irvec[8*i +: 8] = v;
   endtask

   logic [31:0] r;
   int          n;

   initial begin
      RESET = 1'b1; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0; armwdata = 32'd0;
      init_in_h = 1'b0; dev_intreq = '0; dev_irvec = '0; dev_level = '0; bus_bg = 4'd0;
      tick(); tick();
      RESET = 1'b0;

      // Reset state
      arm_read(2'd0, r); check("reg0_id", r, 32'h4941_0100);
      arm_read(2'd1, r); check("reg1_reset", r, 32'h0);
      arm_read(2'd3, r); check("reg3_zero", r, 32'h0);
      check("br_reset", 32'(bus_br), 32'h0);
      check("intgnt_reset", 32'(intgnt), 32'h0);

      // Basic request/grant/drop for dev0, level 2, vector 0o100
      set_dev(0, 1'b1, 2'd2, 8'o100);
      arm_write(2'd1, 32'h8000_0001);
      check("br_old_cfg", 32'(bus_br), 32'h0);
      tick();
      check("br_lvl2", 32'(bus_br), 32'h4);
      arm_read(2'd1, r); check("state_req", 32'(r[29:28]), 32'd1);
      bus_bg = 4'b0100;
      tick();
      bus_bg = 4'b0000;
      check("intgnt_on", 32'(intgnt), 32'h1);
      check("igvec_on", 32'(igvec), 32'h40);
      check("br_after_bg", 32'(bus_br), 32'h0);
      tick();
      check("intgnt_off", 32'(intgnt), 32'h0);
      check("igvec_off", 32'(igvec), 32'h0);
      arm_read(2'd1, r); check("state_drop", 32'(r[29:28]), 32'd3);
      dev_intreq[0] = 1'b0;
      tick();
      arm_read(2'd1, r); check("reg1_after_drop", r, 32'h8040_0001);

      // Priority: dev1 L1, dev2 L3, dev3 L3 -> dev2 wins; wrong-bit BG ignored
      set_dev(1, 1'b1, 2'd1, 8'h11);
      set_dev(2, 1'b1, 2'd3, 8'h22);
      set_dev(3, 1'b1, 2'd3, 8'h33);
      arm_write(2'd1, 32'h8000_000E);
      tick();
      check("br_lvl3", 32'(bus_br), 32'h8);
      arm_read(2'd1, r); check("sel_dev2", 32'(r[27:16]), 32'h222);
      bus_bg = 4'b0100;
      tick();
      check("bg_wrong_br", 32'(bus_br), 32'h8);
      check("bg_wrong_gnt", 32'(intgnt), 32'h0);
      bus_bg = 4'b1000;
      tick();
      bus_bg = 4'b0000;
      check("gnt_dev2", 32'(intgnt), 32'h1);
      check("igvec_dev2", 32'(igvec), 32'h22);
      tick();
      dev_intreq = '0;
      tick();
      arm_read(2'd1, r); check("idle_after_prio", 32'(r[29:28]), 32'd0);
      check("br_idle_prio", 32'(bus_br), 32'h0);

      // Withdraw before grant; BG on level 0 ignored while requesting level 2
      set_dev(0, 1'b1, 2'd2, 8'o100);
      arm_write(2'd1, 32'h8000_0001);
      tick();
      check("br_withdraw_pre", 32'(bus_br), 32'h4);
      bus_bg = 4'b0001;
      tick();
      bus_bg = 4'b0000;
      check("bg0_ignored_br", 32'(bus_br), 32'h4);
      check("bg0_ignored_gnt", 32'(intgnt), 32'h0);
      dev_intreq[0] = 1'b0;
      tick();
      check("br_withdrawn", 32'(bus_br), 32'h0);
      check("gnt_withdrawn", 32'(intgnt), 32'h0);
      arm_read(2'd1, r); check("idle_withdrawn", 32'(r[29:28]), 32'd0);

      // Timeout: granted device keeps intreq asserted
      dev_intreq[0] = 1'b1;
      tick();
      bus_bg = 4'b0100;
      tick();
      bus_bg = 4'b0000;
      n = 0;
      arm_read(2'd1, r);
      while (!r[30] && n < 400) begin
         tick();
         n++;
         arm_read(2'd1, r);
      end
      dev_intreq[0] = 1'b0;
      check("tmo_cycles", 32'(n), 32'd257);
      check("tmo_state_idle", 32'(r[29:28]), 32'd0);
      tick();
      arm_write(2'd1, 32'hC000_0001);
      arm_read(2'd1, r); check("tmo_cleared", r, 32'h8040_0001);

      // INIT during REQ aborts, keeps config
      dev_intreq[0] = 1'b1;
      tick();
      check("br_before_init", 32'(bus_br), 32'h4);
      init_in_h = 1'b1;
      dev_intreq[0] = 1'b0;
      tick();
      init_in_h = 1'b0;
      check("br_after_init", 32'(bus_br), 32'h0);
      arm_read(2'd1, r);
      check("init_state", 32'(r[29:28]), 32'd0);
      check("init_cfg_kept", {r[31], 15'd0, r[15:0]}, 32'h8000_0001);

      // Statistics: three grants so far
`ifdef INTARB_STATS_EN
      arm_read(2'd2, r); check("stats_3", r, 32'd3);
      arm_write(2'd2, 32'h0);
      arm_read(2'd2, r); check("stats_clr", r, 32'd0);
`else
      arm_read(2'd2, r); check("stats_off", r, 32'd0);
      arm_write(2'd2, 32'hFFFF_FFFF);
      arm_read(2'd2, r); check("stats_off_wr", r, 32'd0);
`endif

      // Mask bits at or above NDEV read zero; reg3 stays zero after a write
      arm_write(2'd1, 32'h8000_FF01);
      arm_read(2'd1, r); check("mask_trunc", 32'(r[15:0]), 32'h0001);
      arm_write(2'd3, 32'h1234_5678);
      arm_read(2'd3, r); check("reg3_ro", r, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
